// File: rtl/vending_if.sv
// vending_if -- request/stock/status bundle of the vending mechanism.
//   master : drives serve/change requests, refill data and error clear.
//   slave  : the mechanism; returns done pulses, stock levels, empty flags
//            and sticky error bits.
// With VENDING_MECH_STATS_EN defined, two 16-bit delivery counters are
// added to the bundle (stat_cans_r, stat_dimes_r).
interface vending_if #(
  parameter int STOCK_W = 8
);
  logic               serve_emit_irn_bru;
  logic               change_emit_dime;
  logic               refill_vld;
  logic [STOCK_W-1:0] refill_cans;
  logic [STOCK_W-1:0] refill_dimes;
  logic               err_clr;
  logic               serve_done_r;
  logic               change_done_r;
  logic [STOCK_W-1:0] cans_r;
  logic [STOCK_W-1:0] dimes_r;
  logic               cans_empty_r;
  logic               dimes_empty_r;
  logic [3:0]         err_r;
`ifdef VENDING_MECH_STATS_EN
  logic [15:0]        stat_cans_r;
  logic [15:0]        stat_dimes_r;
`endif

  modport master (
    output serve_emit_irn_bru, change_emit_dime, refill_vld,
           refill_cans, refill_dimes, err_clr,
    input  serve_done_r, change_done_r, cans_r, dimes_r,
           cans_empty_r, dimes_empty_r, err_r
`ifdef VENDING_MECH_STATS_EN
    , input stat_cans_r, stat_dimes_r
`endif
  );

  modport slave (
    input  serve_emit_irn_bru, change_emit_dime, refill_vld,
           refill_cans, refill_dimes, err_clr,
    output serve_done_r, change_done_r, cans_r, dimes_r,
           cans_empty_r, dimes_empty_r, err_r
`ifdef VENDING_MECH_STATS_EN
    , output stat_cans_r, stat_dimes_r
`endif
  );
endinterface

// File: rtl/vending_mech.sv
// vending_mech -- can dispenser / dime changer with stock tracking.
// Two independent IDLE/BUSY/DONE channels (serve, change). A request
// sampled in cycle T gives a one-cycle done pulse in cycle T+LAT. While a
// channel is in DONE its stock counter decrements (never below 0); a DONE
// at zero stock still pulses but sets the sticky empty error. Requests
// arriving while a channel is BUSY/DONE are dropped and flagged as overrun.
// Ports: clk, rst (async, active-high), bus (vending_if.slave).
// Parameters: SERVE_LAT, CHANGE_LAT (1..15), STOCK_W.
// Optional: define VENDING_MECH_STATS_EN for saturating delivery counters.
module vending_mech #(
  parameter int SERVE_LAT  = 4,
  parameter int CHANGE_LAT = 2,
  parameter int STOCK_W    = 8
) (
  input logic       clk,
  input logic       rst,
  vending_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} ch_state_t;

  localparam logic [3:0]         S_LOAD = 4'(SERVE_LAT - 1);
  localparam logic [3:0]         C_LOAD = 4'(CHANGE_LAT - 1);
  localparam logic [STOCK_W-1:0] ONE    = STOCK_W'(1);

  ch_state_t          s_state_q, s_state_d, c_state_q, c_state_d;
  logic [3:0]         s_tmr_q, s_tmr_d, c_tmr_q, c_tmr_d;
  logic               s_done_q, c_done_q;
  logic               s_ovr, c_ovr;
  logic               s_fire, c_fire, s_dry, c_dry;
  logic [STOCK_W-1:0] cans_q, cans_d, dimes_q, dimes_d;
  logic               cans_empty_q, dimes_empty_q;
  logic [3:0]         err_q, err_d;

  // Channel next-state. Timer counts down from LAT-1; the cycle it would
  // reach 0 is the transition into DONE, which lands done in cycle T+LAT.
  always_comb begin
    s_state_d = s_state_q;
    s_tmr_d   = s_tmr_q;
    s_ovr     = 1'b0;
    case (s_state_q)
      IDLE: if (bus.serve_emit_irn_bru) begin
        if (SERVE_LAT == 1) begin
          s_state_d = DONE;
        end else begin
          s_state_d = BUSY;
          s_tmr_d   = S_LOAD;
        end
      end
      BUSY: begin
        s_ovr   = bus.serve_emit_irn_bru;
        s_tmr_d = s_tmr_q - 4'd1;
        if (s_tmr_q == 4'd1) s_state_d = DONE;
      end
      DONE: begin
        s_ovr     = bus.serve_emit_irn_bru;
        s_state_d = IDLE;
      end
      default: s_state_d = IDLE;
    endcase
  end

  always_comb begin
    c_state_d = c_state_q;
    c_tmr_d   = c_tmr_q;
    c_ovr     = 1'b0;
    case (c_state_q)
      IDLE: if (bus.change_emit_dime) begin
        if (CHANGE_LAT == 1) begin
          c_state_d = DONE;
        end else begin
          c_state_d = BUSY;
          c_tmr_d   = C_LOAD;
        end
      end
      BUSY: begin
        c_ovr   = bus.change_emit_dime;
        c_tmr_d = c_tmr_q - 4'd1;
        if (c_tmr_q == 4'd1) c_state_d = DONE;
      end
      DONE: begin
        c_ovr     = bus.change_emit_dime;
        c_state_d = IDLE;
      end
      default: c_state_d = IDLE;
    endcase
  end

  // Stock update: refill wins over the DONE-cycle decrement; a DONE at
  // zero stock leaves the counter at 0 and raises the empty error.
  always_comb begin
    s_fire  = (s_state_q == DONE);
    c_fire  = (c_state_q == DONE);
    s_dry   = s_fire && (cans_q == '0);
    c_dry   = c_fire && (dimes_q == '0);
    cans_d  = cans_q;
    dimes_d = dimes_q;
    if (bus.refill_vld) begin
      cans_d  = bus.refill_cans;
      dimes_d = bus.refill_dimes;
    end else begin
      if (s_fire && !s_dry) cans_d  = cans_q - ONE;
      if (c_fire && !c_dry) dimes_d = dimes_q - ONE;
    end
    // New error events are OR-ed after the clear so a same-cycle set wins.
    err_d = (bus.err_clr ? 4'b0000 : err_q) | {c_ovr, s_ovr, c_dry, s_dry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_state_q     <= IDLE;
      c_state_q     <= IDLE;
      s_tmr_q       <= 4'd0;
      c_tmr_q       <= 4'd0;
      s_done_q      <= 1'b0;
      c_done_q      <= 1'b0;
      cans_q        <= '0;
      dimes_q       <= '0;
      cans_empty_q  <= 1'b1;
      dimes_empty_q <= 1'b1;
      err_q         <= 4'b0000;
    end else begin
      s_state_q     <= s_state_d;
      c_state_q     <= c_state_d;
      s_tmr_q       <= s_tmr_d;
      c_tmr_q       <= c_tmr_d;
      s_done_q      <= (s_state_d == DONE);
      c_done_q      <= (c_state_d == DONE);
      cans_q        <= cans_d;
      dimes_q       <= dimes_d;
      cans_empty_q  <= (cans_d == '0);
      dimes_empty_q <= (dimes_d == '0);
      err_q         <= err_d;
    end
  end

  assign bus.serve_done_r  = s_done_q;
  assign bus.change_done_r = c_done_q;
  assign bus.cans_r        = cans_q;
  assign bus.dimes_r       = dimes_q;
  assign bus.cans_empty_r  = cans_empty_q;
  assign bus.dimes_empty_r = dimes_empty_q;
  assign bus.err_r         = err_q;

`ifdef VENDING_MECH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stat_c_q, stat_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_c_q <= 16'd0;
      stat_d_q <= 16'd0;
    end else begin
      if (s_fire && !s_dry) stat_c_q <= sat_inc(stat_c_q);
      if (c_fire && !c_dry) stat_d_q <= sat_inc(stat_d_q);
    end
  end

  assign bus.stat_cans_r  = stat_c_q;
  assign bus.stat_dimes_r = stat_d_q;
`endif

endmodule

// File: tb/tb_vending_mech.sv
module tb_vending_mech;
  localparam int SL = 4;
  localparam int CL = 2;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vending_if #(.STOCK_W(SW)) bus();
  vending_mech #(.SERVE_LAT(SL), .CHANGE_LAT(CL), .STOCK_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         s, c, rv;
    logic [7:0] rc, rd;
    bit         clr;
    bit         esd, ecd;
    logic [7:0] ecans, edimes;
    logic [3:0] eerr;
  } vec_t;
  vec_t tbl[9];

  // reference model state
  int         cyc, s_due, c_due;
  logic [7:0] mcans, mdimes;
  logic [3:0] merr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.serve_emit_irn_bru = 1'b0;
    bus.change_emit_dime   = 1'b0;
    bus.refill_vld         = 1'b0;
    bus.refill_cans        = '0;
    bus.refill_dimes       = '0;
    bus.err_clr            = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic refill(input logic [7:0] c, input logic [7:0] d);
    bus.refill_vld   = 1'b1;
    bus.refill_cans  = c;
    bus.refill_dimes = d;
    step();
    idle_in();
  endtask

  function automatic logic [23:0] obs();
    return {bus.serve_done_r, bus.change_done_r, bus.cans_r, bus.dimes_r,
            bus.cans_empty_r, bus.dimes_empty_r, bus.err_r};
  endfunction

  // One random cycle: model the spec from request times and stock arithmetic.
  task automatic rand_cycle();
    bit         sv, cv, rv, clr, sd_now, cd_now;
    logic [7:0] rc, rd;
    logic [3:0] set;
    sv  = ($urandom_range(0, 3) == 0);
    cv  = ($urandom_range(0, 2) == 0);
    rv  = ($urandom_range(0, 15) == 0);
    clr = ($urandom_range(0, 11) == 0);
    rc  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 6));
    rd  = 8'($urandom_range(0, 4));
    bus.serve_emit_irn_bru = sv;
    bus.change_emit_dime   = cv;
    bus.refill_vld         = rv;
    bus.refill_cans        = rc;
    bus.refill_dimes       = rd;
    bus.err_clr            = clr;

    set    = 4'b0000;
    sd_now = (cyc == s_due);
    cd_now = (cyc == c_due);
    if (sv) begin
      if (s_due < cyc) s_due = cyc + SL; else set[2] = 1'b1;
    end
    if (cv) begin
      if (c_due < cyc) c_due = cyc + CL; else set[3] = 1'b1;
    end
    if (sd_now && mcans == 0)  set[0] = 1'b1;
    if (cd_now && mdimes == 0) set[1] = 1'b1;
    if (rv) begin
      mcans  = rc;
      mdimes = rd;
    end else begin
      if (sd_now && mcans != 0)  mcans  = mcans - 8'd1;
      if (cd_now && mdimes != 0) mdimes = mdimes - 8'd1;
    end
    merr = (clr ? 4'b0000 : merr) | set;

    step();
    cyc++;
    chk("random", 64'(obs()),
        64'({(cyc == s_due), (cyc == c_due), mcans, mdimes,
             (mcans == 8'd0), (mdimes == 8'd0), merr}));
  endtask

  initial begin
    int npulse;
    idle_in();

    // ---------------- reset values while rst is high
    rst = 1'b1;
    step();
    step();
    chk("reset_state", 64'(obs()), 64'({1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 4'h0}));
    rst = 1'b0;
    step();

    // ---------------- table: refill, simultaneous serve/change, overrun, clear
    tbl[0] = '{0, 0, 1, 8'd5, 8'd3, 0, 0, 0, 8'd5, 8'd3, 4'h0};
    tbl[1] = '{1, 1, 0, 8'd0, 8'd0, 0, 0, 0, 8'd5, 8'd3, 4'h0};
    tbl[2] = '{0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 8'd5, 8'd3, 4'h0};
    tbl[3] = '{0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd5, 8'd2, 4'h0};
    tbl[4] = '{0, 0, 0, 8'd0, 8'd0, 0, 1, 0, 8'd5, 8'd2, 4'h0};
    tbl[5] = '{0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd4, 8'd2, 4'h0};
    tbl[6] = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 8'd4, 8'd2, 4'h0};
    tbl[7] = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 1, 8'd4, 8'd2, 4'h8};
    tbl[8] = '{0, 0, 0, 8'd0, 8'd0, 1, 0, 0, 8'd4, 8'd1, 4'h0};
    for (int i = 0; i < 9; i++) begin
      bus.serve_emit_irn_bru = tbl[i].s;
      bus.change_emit_dime   = tbl[i].c;
      bus.refill_vld         = tbl[i].rv;
      bus.refill_cans        = tbl[i].rc;
      bus.refill_dimes       = tbl[i].rd;
      bus.err_clr            = tbl[i].clr;
      step();
      chk($sformatf("table_row%0d", i), 64'(obs()),
          64'({tbl[i].esd, tbl[i].ecd, tbl[i].ecans, tbl[i].edimes,
               (tbl[i].ecans == 8'd0), (tbl[i].edimes == 8'd0), tbl[i].eerr}));
    end
    idle_in();
    step();

    // ---------------- serve latency with cans=3
    refill(8'd3, 8'd2);
    bus.serve_emit_irn_bru = 1'b1;
    step();
    idle_in();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("serve_lat_k%0d", k), 64'(bus.serve_done_r), 64'(k == SL));
      if (k < 5) step();
    end
    chk("serve_cans_after", 64'(bus.cans_r), 64'd2);

    // ---------------- three change requests on dimes=2
    for (int p = 0; p < 3; p++) begin
      bus.change_emit_dime = 1'b1;
      step();
      idle_in();
      chk($sformatf("chg%0d_k1", p), 64'(bus.change_done_r), 64'd0);
      step();
      chk($sformatf("chg%0d_k2", p), 64'(bus.change_done_r), 64'd1);
      step();
    end
    chk("chg_dimes_end", 64'({bus.dimes_r, bus.dimes_empty_r}), 64'({8'd0, 1'b1}));
    chk("chg_err_empty", 64'(bus.err_r), 64'h2);
    bus.err_clr = 1'b1;
    step();
    idle_in();
    chk("chg_err_clr", 64'(bus.err_r), 64'h0);

    // ---------------- serve overrun 2 cycles after a serve
    bus.serve_emit_irn_bru = 1'b1;
    step();
    idle_in();
    step();
    bus.serve_emit_irn_bru = 1'b1;
    step();
    idle_in();
    npulse = 0;
    for (int k = 3; k <= 8; k++) begin
      if (bus.serve_done_r) npulse++;
      step();
    end
    chk("ovr_one_pulse", 64'(npulse), 64'd1);
    chk("ovr_err", 64'(bus.err_r), 64'h4);
    chk("ovr_cans", 64'(bus.cans_r), 64'd1);
    bus.err_clr = 1'b1;
    step();
    idle_in();
    chk("ovr_err_clr", 64'(bus.err_r), 64'h0);

    // ---------------- refill wins over decrement in the DONE cycle
    bus.serve_emit_irn_bru = 1'b1;
    step();
    idle_in();
    for (int k = 1; k < SL; k++) step();
    chk("rf_done_seen", 64'(bus.serve_done_r), 64'd1);
    bus.refill_vld   = 1'b1;
    bus.refill_cans  = 8'd5;
    bus.refill_dimes = 8'd0;
    step();
    idle_in();
    chk("rf_priority", 64'({bus.cans_r, bus.cans_empty_r}), 64'({8'd5, 1'b0}));

    // ---------------- reset during BUSY aborts the pending done
    bus.serve_emit_irn_bru = 1'b1;
    step();
    idle_in();
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_async", 64'(obs()), 64'({1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 4'h0}));
    step();
    rst = 1'b0;
    npulse = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.serve_done_r) npulse++;
    end
    chk("rst_mid_no_pulse", 64'(npulse), 64'd0);

`ifdef VENDING_MECH_STATS_EN
    // ---------------- 3 good serves + 1 at empty
    do_reset();
    step();
    refill(8'd3, 8'd0);
    for (int p = 0; p < 4; p++) begin
      bus.serve_emit_irn_bru = 1'b1;
      step();
      idle_in();
      for (int k = 0; k < SL; k++) step();
    end
    chk("stat_cans", 64'(bus.stat_cans_r), 64'd3);
    chk("stat_err_empty", 64'(bus.err_r), 64'h1);
`endif

    // ---------------- randomized run against the reference model
    do_reset();
    cyc    = 0;
    s_due  = -100;
    c_due  = -100;
    mcans  = 8'd0;
    mdimes = 8'd0;
    merr   = 4'h0;
    for (int n = 0; n < 600; n++) rand_cycle();
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
